// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with x86-style {OF,SF,ZF,AF,PF,CF} flags for the v30mz execution unit.
// Define ALU_MUL_EN to enable the shift-add unsigned multiply on op 12; otherwise op 12 is illegal.
module alu_seq #(
    parameter int WIDTH    = 16,
    parameter int CNT_BITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cf_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] R_hi,
    output logic [5:0]       flags,
    output logic             err
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = (CNT_BITS > $clog2(WIDTH + 1)) ? CNT_BITS : $clog2(WIDTH + 1);
    localparam logic [15:0] ILLEGAL_R = 16'hFACE;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SHL = 4'd2,  OP_SHR = 4'd3,
        OP_ROL = 4'd4, OP_ROR = 4'd5, OP_ADC = 4'd6,  OP_SBB = 4'd7,
        OP_AND = 4'd8, OP_OR  = 4'd9, OP_XOR = 4'd10, OP_SAR = 4'd11,
        OP_MUL = 4'd12
    } op_t;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_nx;
    logic             accept, is_shift, do_shift;
    logic [CW-1:0]    cnt_in, sh_cnt;
    logic [3:0]       sh_op;
    logic [WIDTH-1:0] sh_val, step_val, sc_r;
    logic             step_out, sh_a_msb, cin, ovf, af, sc_err;
    logic [WIDTH:0]   sum;
    logic [5:0]       sc_flags, step_flags;

    assign accept   = in_valid & in_ready;
    assign is_shift = alu_op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_SAR};
    assign cnt_in   = CW'(B[CNT_BITS-1:0]);
    assign do_shift = is_shift && (cnt_in != '0);

    // Single-cycle result; zero-count shifts pass A through with flags untouched.
    always_comb begin
        cin      = (alu_op == OP_ADC || alu_op == OP_SBB) ? cf_in : 1'b0;
        sum      = '0;
        ovf      = 1'b0;
        sc_r     = '0;
        sc_err   = 1'b0;
        sc_flags = flags;
        case (alu_op)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
                ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB, OP_SBB: begin
                sum = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, cin};
                ovf = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
            end
            default: ;
        endcase
        af = A[4] ^ B[4] ^ sum[4];
        case (alu_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                sc_r     = sum[MSB:0];
                sc_flags = {ovf, sum[MSB], sum[MSB:0] == '0, af, ~^sum[7:0], sum[WIDTH]};
            end
            OP_AND, OP_OR, OP_XOR: begin
                sc_r     = (alu_op == OP_AND) ? (A & B) : (alu_op == OP_OR) ? (A | B) : (A ^ B);
                sc_flags = {1'b0, sc_r[MSB], sc_r == '0, 1'b0, ~^sc_r[7:0], 1'b0};
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_SAR: sc_r = A;
`ifdef ALU_MUL_EN
            OP_MUL: ;
`endif
            default: begin
                sc_r   = ILLEGAL_R[MSB:0];
                sc_err = 1'b1;
            end
        endcase
    end

    // One bit of shift/rotate per cycle; flags are formed from the post-step value.
    always_comb begin
        step_val = sh_val;
        step_out = 1'b0;
        case (sh_op)
            OP_SHL: begin step_val = {sh_val[MSB-1:0], 1'b0};       step_out = sh_val[MSB]; end
            OP_ROL: begin step_val = {sh_val[MSB-1:0], sh_val[MSB]}; step_out = sh_val[MSB]; end
            OP_SHR: begin step_val = {1'b0, sh_val[MSB:1]};          step_out = sh_val[0];   end
            OP_SAR: begin step_val = {sh_val[MSB], sh_val[MSB:1]};   step_out = sh_val[0];   end
            OP_ROR: begin step_val = {sh_val[0], sh_val[MSB:1]};     step_out = sh_val[0];   end
            default: ;
        endcase
        step_flags    = flags;
        step_flags[0] = step_out;
        step_flags[2] = 1'b0;
        case (sh_op)
            OP_SHL, OP_ROL: step_flags[5] = step_val[MSB] ^ step_out;
            OP_SHR:         step_flags[5] = sh_a_msb;
            OP_ROR:         step_flags[5] = step_val[MSB] ^ step_val[MSB-1];
            default:        step_flags[5] = 1'b0;
        endcase
        if (sh_op == OP_SHL || sh_op == OP_SHR || sh_op == OP_SAR) begin
            step_flags[4] = step_val[MSB];
            step_flags[3] = (step_val == '0);
            step_flags[1] = ~^step_val[7:0];
        end
    end

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_acc_nx;
    logic [WIDTH-1:0]   mul_mplr;
    logic [5:0]         mul_flags;
    logic               mul_hi_nz;

    always_comb begin
        mul_acc_nx = mul_mplr[0] ? (mul_acc + mul_mcand) : mul_acc;
        mul_hi_nz  = (mul_acc_nx[2*WIDTH-1:WIDTH] != '0);
        mul_flags  = {mul_hi_nz, mul_acc_nx[MSB], mul_acc_nx[MSB:0] == '0, 1'b0,
                      ~^mul_acc_nx[7:0], mul_hi_nz};
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && do_shift) state_nx = SHIFT;
`ifdef ALU_MUL_EN
                else if (accept && alu_op == OP_MUL) state_nx = MUL;
`endif
            end
            SHIFT:   if (sh_cnt == CW'(1)) state_nx = IDLE;
`ifdef ALU_MUL_EN
            MUL:     if (sh_cnt == CW'(1)) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_comb in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            R         <= '0;
            R_hi      <= '0;
            flags     <= '0;
            err       <= 1'b0;
            sh_val    <= '0;
            sh_cnt    <= '0;
            sh_op     <= '0;
            sh_a_msb  <= 1'b0;
`ifdef ALU_MUL_EN
            mul_acc   <= '0;
            mul_mcand <= '0;
            mul_mplr  <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (do_shift) begin
                        sh_val   <= A;
                        sh_cnt   <= cnt_in;
                        sh_op    <= alu_op;
                        sh_a_msb <= A[MSB];
                    end
`ifdef ALU_MUL_EN
                    else if (alu_op == OP_MUL) begin
                        mul_acc   <= '0;
                        mul_mcand <= {{WIDTH{1'b0}}, A};
                        mul_mplr  <= B;
                        sh_cnt    <= CW'(WIDTH);
                    end
`endif
                    else begin
                        out_valid <= 1'b1;
                        R         <= sc_r;
                        R_hi      <= '0;
                        flags     <= sc_flags;
                        err       <= sc_err;
                    end
                end
                SHIFT: begin
                    sh_val <= step_val;
                    sh_cnt <= sh_cnt - CW'(1);
                    if (sh_cnt == CW'(1)) begin
                        out_valid <= 1'b1;
                        R         <= step_val;
                        R_hi      <= '0;
                        flags     <= step_flags;
                        err       <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    mul_acc   <= mul_acc_nx;
                    mul_mcand <= mul_mcand << 1;
                    mul_mplr  <= mul_mplr >> 1;
                    sh_cnt    <= sh_cnt - CW'(1);
                    if (sh_cnt == CW'(1)) begin
                        out_valid <= 1'b1;
                        R         <= mul_acc_nx[MSB:0];
                        R_hi      <= mul_acc_nx[2*WIDTH-1:WIDTH];
                        flags     <= mul_flags;
                        err       <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: an arithmetic reference model queues expected results at accept,
// and a monitor pops and compares them (including completion cycle) whenever out_valid is seen.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [15:0] a_in, b_in;
    logic        cf_in;
    logic        out_valid;
    logic [15:0] R, R_hi;
    logic [5:0]  flags;
    logic        err;

    alu_seq #(.WIDTH(16), .CNT_BITS(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .A(a_in), .B(b_in), .cf_in(cf_in),
        .out_valid(out_valid), .R(R), .R_hi(R_hi), .flags(flags), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [15:0] r_hi;
        logic [5:0]  fl;
        logic        er;
        int unsigned due;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [5:0]  m_flags = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic par(input logic [15:0] v);
        return ($countones(v[7:0]) % 2) == 0;
    endfunction

    // Reference model: results from plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic [5:0] fl_prev, input int unsigned now);
        exp_t   e;
        int     ai, bi, sa, sb, ci, s, ss, tmp, n, k, lat;
        longint t;
        logic [15:0] r;
        logic   of, cf, af;
        ai = a; bi = b; sa = $signed(a); sb = $signed(b);
        n  = b[4:0];
        k  = n % 16;
        ci = ((op == 4'd6 || op == 4'd7) && c) ? 1 : 0;
        e.fl = fl_prev; e.er = 1'b0; e.r_hi = '0; lat = 1; r = '0;
        case (op)
            4'd0, 4'd6: begin
                s = ai + bi + ci; r = s[15:0]; cf = s[16];
                af = ((ai % 16) + (bi % 16) + ci) > 15;
                ss = sa + sb + ci; of = (ss > 32767) || (ss < -32768);
                e.fl = {of, r[15], r == 16'h0, af, par(r), cf};
            end
            4'd1, 4'd7: begin
                s = ai - bi - ci; r = s[15:0]; cf = (s < 0);
                af = ((ai % 16) - (bi % 16) - ci) < 0;
                ss = sa - sb - ci; of = (ss > 32767) || (ss < -32768);
                e.fl = {of, r[15], r == 16'h0, af, par(r), cf};
            end
            4'd8, 4'd9, 4'd10: begin
                r = (op == 4'd8) ? (a & b) : (op == 4'd9) ? (a | b) : (a ^ b);
                e.fl = {1'b0, r[15], r == 16'h0, 1'b0, par(r), 1'b0};
            end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd11: begin
                if (n == 0) r = a;
                else begin
                    lat = n + 1;
                    case (op)
                        4'd2: begin
                            t = longint'(ai) << n; r = t[15:0]; cf = t[16];
                            e.fl = {r[15] ^ cf, r[15], r == 16'h0, 1'b0, par(r), cf};
                        end
                        4'd3: begin
                            tmp = ai >> n; r = tmp[15:0];
                            tmp = ai >> (n - 1); cf = tmp[0];
                            e.fl = {a[15], r[15], r == 16'h0, 1'b0, par(r), cf};
                        end
                        4'd11: begin
                            tmp = sa >>> n; r = tmp[15:0];
                            tmp = sa >>> (n - 1); cf = tmp[0];
                            e.fl = {1'b0, r[15], r == 16'h0, 1'b0, par(r), cf};
                        end
                        4'd4: begin
                            tmp = (ai << k) | (ai >> (16 - k)); r = tmp[15:0]; cf = r[0];
                            e.fl = {r[15] ^ cf, fl_prev[4], fl_prev[3], 1'b0, fl_prev[1], cf};
                        end
                        default: begin
                            tmp = (ai >> k) | (ai << (16 - k)); r = tmp[15:0]; cf = r[15];
                            e.fl = {r[15] ^ r[14], fl_prev[4], fl_prev[3], 1'b0, fl_prev[1], cf};
                        end
                    endcase
                end
            end
`ifdef ALU_MUL_EN
            4'd12: begin
                t = longint'(ai) * longint'(bi);
                r = t[15:0]; e.r_hi = t[31:16]; lat = 17;
                e.fl = {e.r_hi != 0, r[15], r == 16'h0, 1'b0, par(r), e.r_hi != 0};
            end
`endif
            default: begin
                r = 16'hFACE; e.er = 1'b1;
            end
        endcase
        e.r   = r;
        e.due = now + lat;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic c);
        exp_t        e;
        int unsigned waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1; alu_op = op; a_in = a; b_in = b; cf_in = c;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready %0b expected 1 after %0d cycles", in_ready, waited);
            in_valid = 1'b0;
            return;
        end
        e = model(op, a, b, c, m_flags, cyc);
        m_flags = e.fl;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL spurious_out_valid: got out_valid 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("R", 32'(R), 32'(e.r));
                check("R_hi", 32'(R_hi), 32'(e.r_hi));
                check("flags", 32'(flags), 32'(e.fl));
                check("err", 32'(err), 32'(e.er));
                check("completion_cycle", cyc, e.due);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int unsigned waited;
        reset = 1'b1; in_valid = 1'b0; alu_op = '0; a_in = '0; b_in = '0; cf_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_R", 32'(R), 32'd0);
        check("reset_R_hi", 32'(R_hi), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset = 1'b0;

        issue(4'd0, 16'h7FFF, 16'h0001, 1'b0);
        idle();
        issue(4'd1, 16'h0000, 16'h0001, 1'b0);
        issue(4'd6, 16'hFFFF, 16'h0000, 1'b1);
        idle();

        issue(4'd2, 16'h8001, 16'h0003, 1'b0);
        idle(); check("shl_busy_c1", 32'(in_ready), 32'd0);
        idle(); check("shl_busy_c2", 32'(in_ready), 32'd0);
        idle(); check("shl_busy_c3", 32'(in_ready), 32'd0);
        idle(); check("shl_ready_c4", 32'(in_ready), 32'd1);

        issue(4'd5, 16'h0001, 16'h0021, 1'b0);
        issue(4'd11, 16'h8000, 16'h0004, 1'b0);
        issue(4'd2, 16'h1234, 16'h0020, 1'b0);

        issue(4'd2, 16'h1234, 16'h0010, 1'b0);
        repeat (5) idle();
        reset = 1'b1;
        sb_q.delete();
        m_flags = '0;
        @(negedge clk);
        check("midop_reset_in_ready", 32'(in_ready), 32'd1);
        check("midop_reset_out_valid", 32'(out_valid), 32'd0);
        check("midop_reset_R", 32'(R), 32'd0);
        check("midop_reset_flags", 32'(flags), 32'd0);
        reset = 1'b0;

        issue(4'd0, 16'h7FFF, 16'h0001, 1'b0);
        issue(4'd13, 16'h0102, 16'h0304, 1'b0);
        issue(4'd15, 16'h0000, 16'h0000, 1'b1);
        issue(4'd12, 16'h1234, 16'h0100, 1'b0);
        idle();

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [15:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom);
            else b = 16'($urandom_range(0, 20)) | (16'($urandom_range(0, 7)) << 5);
            issue(op, a, b, 1'($urandom));
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();

        waited = 0;
        while (sb_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_pending_results", sb_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational ALU for the v30mz execution unit.
- Adds logic ops, carry-in ops (ADC/SBB), arithmetic right shift, and a 6-bit x86-style flag set.
- Shifts and rotates take a variable count and execute one bit per cycle.
- Sits between the microcode sequencer (issues ops) and the register file / flag register (consume results).

Parameters:
- WIDTH, 16, operand/result width; 8 and 16 supported.
- CNT_BITS, 5, shift/rotate count taken from B[CNT_BITS-1:0]; upper B bits ignored.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  op request
- in_ready  out  1  block can accept an op this cycle
- alu_op  in  4  0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ADC, 7 SBB, 8 AND, 9 OR, 10 XOR, 11 SAR, 12 MUL (optional), 13-15 illegal
- A  in  WIDTH  operand A / shift source
- B  in  WIDTH  operand B / shift count
- cf_in  in  1  carry-in for ADC/SBB
- out_valid  out  1  one-cycle result strobe
- R  out  WIDTH  result, held until next completion
- R_hi  out  WIDTH  MUL high half; 0 otherwise
- flags  out  6  {OF,SF,ZF,AF,PF,CF}, held with R
- err  out  1  high with out_valid for an illegal op

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, R=0, R_hi=0, flags=0, err=0, FSM=IDLE.
- Reset mid-operation: abandons the op, no out_valid, IDLE next cycle.
- Handshake: accept when in_valid & in_ready; that is cycle 0. A, B, alu_op, cf_in are sampled only at accept.
- FSM states: IDLE (in_ready=1), SHIFT, MUL.
- Single-cycle ops (ADD, SUB, ADC, SBB, AND, OR, XOR, illegal, and any shift with masked count 0):
  - out_valid in cycle 1; FSM stays IDLE.
  - Back-to-back accepts give one result per cycle.
- Shift/rotate with masked count N>=1:
  - IDLE->SHIFT; one bit step per cycle; in_ready=0 in cycles 1..N.
  - out_valid in cycle N+1; SHIFT->IDLE on the last step.
- Shift with count 0: R=A, flags unchanged from the previous value.
- Arithmetic:
  - WIDTH+1-bit sum; CF = carry out (borrow for SUB/SBB).
  - ADC adds cf_in; SBB subtracts cf_in.
  - OF = signed overflow; AF = carry/borrow out of bit 3.
- Logic ops: CF=OF=AF=0.
- Flags for all result-producing ops: ZF = (R==0); SF = R[WIDTH-1]; PF = even parity of R[7:0] (1 when even).
- Shift flags:
  - CF = last bit shifted/rotated out.
  - SHL/ROL: OF = R[msb]^CF.
  - SHR: OF = A[msb].
  - SAR: OF = 0; sign bit is replicated.
  - ROR: OF = R[msb]^R[msb-1].
  - AF = 0; rotates leave ZF/SF/PF unchanged.
- Illegal ops: R = 16'hFACE truncated to WIDTH; flags unchanged; err=1.
- err, out_valid, and R_hi are cleared/updated only on completion; out_valid is never asserted twice per accept.
- in_valid while in_ready=0 is ignored; the sequencer holds the request.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: op 12 is an unsigned WIDTH x WIDTH shift-add multiply.
  - IDLE->MUL for WIDTH cycles; out_valid in cycle WIDTH+1.
  - R = low half, R_hi = high half; CF=OF=(R_hi!=0); ZF/SF/PF from R; AF=0.
- Undefined: op 12 is illegal (R=FACE, err=1); the MUL state is absent; R_hi tied 0.

Test Plan:
- ADD A=7FFF B=0001 -> cycle 1: R=8000, OF=1, SF=1, ZF=0, AF=1, PF=1, CF=0.
- SUB A=0000 B=0001 -> R=FFFF, CF=1, SF=1, AF=1, OF=0, PF=1. ADC A=FFFF B=0000 cf_in=1 on the next cycle -> R=0000, ZF=1, CF=1; out_valid high on consecutive cycles.
- SHL A=8001 B=0003 -> in_ready=0 cycles 1-3; cycle 4: R=0008, CF=0; exactly one out_valid.
- ROR A=0001 B=0021 (count masks to 1) -> cycle 2: R=8000, CF=1, OF=1. SAR A=8000 B=0004 -> R=F800, CF=0.
- SHL A=1234 B=0010, reset asserted in cycle 5 -> cycle 6: in_ready=1, out_valid=0, R=0, flags=0. Illegal op 13 -> R=FACE, err=1, flags unchanged.
- ALU_MUL_EN: MUL A=1234 B=0100 -> cycle 17: R=3400, R_hi=0012, CF=OF=1. Without the macro, same stimulus -> cycle 1: R=FACE, err=1.
